// File: rtl/class_switch_n.sv
// class_switch_n: one input FIFO feeding NUM_CH output FIFOs, routed by a class field in each word.
// Optional per-channel routed-word counters are compiled in with `define CLASS_SWITCH_STATS_EN.
module class_switch_n #(
    parameter int DATA_SIZE = 10,
    parameter int NUM_CH    = 4,
    parameter int CLASS_LSB = 8,
    parameter int IN_DEPTH  = 8,
    parameter int OUT_DEPTH = 4,
    parameter int AF_LVL    = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [DATA_SIZE-1:0]        in,
    output logic                        in_full,
    input  logic [NUM_CH-1:0]           pop,
    output logic [NUM_CH*DATA_SIZE-1:0] out,
    output logic [NUM_CH-1:0]           out_valid,
    output logic [NUM_CH-1:0]           fifo_empty,
    output logic [NUM_CH-1:0]           fifo_almostfull,
`ifdef CLASS_SWITCH_STATS_EN
    input  logic [$clog2(NUM_CH)-1:0]   stat_sel,
    input  logic                        stat_clr,
    output logic [15:0]                 stat_cnt,
`endif
    output logic                        Error
);
    localparam int CW  = $clog2(NUM_CH);
    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam logic [IAW:0] IN_CAP = IN_DEPTH[IAW:0];
    localparam logic [IAW:0] IN_ONE = (IAW+1)'(1);
    localparam logic [OAW:0] AF_CNT = AF_LVL[OAW:0];

    typedef enum logic [1:0] {INIT, IDLE, ROUTE, STALL} state_t;
    state_t state, state_nx;

    logic [DATA_SIZE-1:0] in_mem [IN_DEPTH];
    logic [IAW-1:0]       in_wr, in_rd;
    logic [IAW:0]         in_cnt;
    logic                 in_empty, in_push, move, af_c, err_set;
    logic [DATA_SIZE-1:0] head;
    logic [CW-1:0]        cls;

    assign in_full  = (in_cnt == IN_CAP);
    assign in_empty = (in_cnt == '0);
    assign head     = in_mem[in_rd];
    assign cls      = head[CLASS_LSB +: CW];
    assign af_c     = fifo_almostfull[cls];
    // A push into a full FIFO is still taken when the router frees a slot in the same cycle.
    assign in_push  = push && (!in_full || move);
    assign err_set  = (push && !in_push) || (|(pop & fifo_empty));

    always_ff @(posedge clk) begin
        if (!reset) state <= INIT;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            INIT:  state_nx = IDLE;
            IDLE:  if (!in_empty || in_push) state_nx = ROUTE;
            ROUTE, STALL: begin
                if (in_empty)                           state_nx = IDLE;
                else if (af_c)                          state_nx = STALL;
                else if (in_cnt == IN_ONE && !in_push)  state_nx = IDLE;
                else                                    state_nx = ROUTE;
            end
            default: state_nx = INIT;
        endcase
    end

    always_comb begin
        move = 1'b0;
        if ((state == ROUTE || state == STALL) && !in_empty && !af_c) move = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset && in_push) in_mem[in_wr] <= in;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_wr  <= '0;
            in_rd  <= '0;
            in_cnt <= '0;
        end else begin
            if (in_push) in_wr <= in_wr + IAW'(1);
            if (move)    in_rd <= in_rd + IAW'(1);
            in_cnt <= in_cnt + (IAW+1)'(in_push) - (IAW+1)'(move);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)       Error <= 1'b0;
        else if (err_set) Error <= 1'b1;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam logic [CW-1:0] KC = CW'(k);
        logic [DATA_SIZE-1:0] mem [OUT_DEPTH];
        logic [OAW-1:0]       wr_ptr, rd_ptr;
        logic [OAW:0]         cnt, cnt_nx;
        logic [DATA_SIZE-1:0] dout;
        logic                 wr, rd, vld, empty, afull;

        assign wr     = move && (cls == KC);
        assign rd     = pop[k] && !empty;
        assign cnt_nx = cnt + (OAW+1)'(wr) - (OAW+1)'(rd);

        always_ff @(posedge clk) begin
            if (reset && wr) mem[wr_ptr] <= head;
        end

        // Flags are registered from the occupancy the FIFO will hold after this edge.
        always_ff @(posedge clk) begin
            if (!reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                dout   <= '0;
                vld    <= 1'b0;
                empty  <= 1'b1;
                afull  <= 1'b0;
            end else begin
                if (wr) wr_ptr <= wr_ptr + OAW'(1);
                if (rd) begin
                    rd_ptr <= rd_ptr + OAW'(1);
                    dout   <= mem[rd_ptr];
                end
                vld   <= rd;
                cnt   <= cnt_nx;
                empty <= (cnt_nx == '0);
                afull <= (cnt_nx >= AF_CNT);
            end
        end

        assign out[k*DATA_SIZE +: DATA_SIZE] = dout;
        assign out_valid[k]       = vld;
        assign fifo_empty[k]      = empty;
        assign fifo_almostfull[k] = afull;
    end

`ifdef CLASS_SWITCH_STATS_EN
    logic [15:0] stat_mem [NUM_CH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NUM_CH; k++) stat_mem[k] <= '0;
            stat_cnt <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (stat_clr)
                    stat_mem[k] <= '0;
                else if (move && cls == CW'(k) && stat_mem[k] != 16'hFFFF)
                    stat_mem[k] <= stat_mem[k] + 16'd1;
            end
            stat_cnt <= stat_mem[stat_sel];
        end
    end
`endif
endmodule
